// File: rtl/i2c_master_ctrl.sv
//==============================================================================
// Module : i2c_master_ctrl
// Brief  : Single-master I2C controller issuing one-byte memory read/write
//          transactions (START, addr+R/W, ACK, data, ACK/NACK, STOP).
// Rev    : 1.0 - initial release
//==============================================================================
`default_nettype none

module i2c_master_ctrl #(
  parameter int data_wd = 8,
  parameter int addr_wd = 7,
  parameter int CLK_DIV = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic               cmd_rw,
  input  logic [addr_wd-1:0] cmd_addr,
  input  logic [data_wd-1:0] cmd_wdata,
  output logic               rsp_valid,
  output logic [data_wd-1:0] rsp_rdata,
  output logic               rsp_nack,
  output logic               busy,
  output logic               scl,
  output logic               sda_oe,
  input  logic               sda_in
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BIT_W = $clog2(addr_wd + data_wd + 1);
  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] ADDR_LAST = BIT_W'(addr_wd);
  localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(data_wd - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_ADDR  = 3'd2,
    S_AACK  = 3'd3,
    S_WDATA = 3'd4,
    S_RDATA = 3'd5,
    S_DACK  = 3'd6,
    S_STOP  = 3'd7
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic [DIV_W-1:0]   div_cnt;
  logic [1:0]         quarter;
  logic [BIT_W-1:0]   bit_cnt;
  logic               rw_lat;
  logic [addr_wd:0]   addr_sh;   // {address, R/W}, shifted out MSB first
  logic [data_wd-1:0] data_sh;   // write byte out / read byte in
  logic               nack_flag;

  logic tick;
  logic sample;
  logic bit_end;
  logic accept;

  assign tick    = (div_cnt == DIV_LAST);
  assign sample  = tick && (quarter == 2'd2);   // last clk of Q2
  assign bit_end = tick && (quarter == 2'd3);   // last clk of Q3
  assign accept  = cmd_valid && cmd_ready;
  assign busy    = (state != S_IDLE) || rsp_valid;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state and bus pin decode; scl is high in Q2/Q3 of every bit period
  always_comb begin
    state_nxt = state;
    cmd_ready = 1'b0;
    scl       = 1'b1;
    sda_oe    = 1'b0;
    case (state)
      S_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) state_nxt = S_START;
      end
      S_START: begin
        sda_oe = quarter[1];
        if (bit_end) state_nxt = S_ADDR;
      end
      S_ADDR: begin
        scl    = quarter[1];
        sda_oe = ~addr_sh[addr_wd];
        if (bit_end && bit_cnt == ADDR_LAST) state_nxt = S_AACK;
      end
      S_AACK: begin
        scl = quarter[1];
        if (bit_end) begin
          if (nack_flag)   state_nxt = S_STOP;
          else if (rw_lat) state_nxt = S_RDATA;
          else             state_nxt = S_WDATA;
        end
      end
      S_WDATA: begin
        scl    = quarter[1];
        sda_oe = ~data_sh[data_wd-1];
        if (bit_end && bit_cnt == DATA_LAST) state_nxt = S_DACK;
      end
      S_RDATA: begin
        scl = quarter[1];
        if (bit_end && bit_cnt == DATA_LAST) state_nxt = S_DACK;
      end
      S_DACK: begin
        scl = quarter[1];
        if (bit_end) state_nxt = S_STOP;
      end
      S_STOP: begin
        scl    = quarter[1];
        sda_oe = (quarter != 2'd3);
        if (bit_end) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Quarter-period divider and per-state bit counter, parked at zero in IDLE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
      quarter <= 2'd0;
      bit_cnt <= '0;
    end else if (state == S_IDLE) begin
      div_cnt <= '0;
      quarter <= 2'd0;
      bit_cnt <= '0;
    end else begin
      div_cnt <= tick ? '0 : div_cnt + DIV_W'(1);
      if (tick) quarter <= quarter + 2'd1;
      if (bit_end) bit_cnt <= (state_nxt != state) ? '0 : bit_cnt + BIT_W'(1);
    end
  end

  // Command capture, shift registers and NACK tracking
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rw_lat    <= 1'b0;
      addr_sh   <= '0;
      data_sh   <= '0;
      nack_flag <= 1'b0;
    end else if (accept) begin
      rw_lat    <= cmd_rw;
      addr_sh   <= {cmd_addr, cmd_rw};
      data_sh   <= cmd_rw ? '0 : cmd_wdata;
      nack_flag <= 1'b0;
    end else begin
      if (bit_end && state == S_ADDR)
        addr_sh <= {addr_sh[addr_wd-1:0], 1'b0};
      if (bit_end && state == S_WDATA)
        data_sh <= {data_sh[data_wd-2:0], 1'b0};
      if (sample && state == S_RDATA)
        data_sh <= {data_sh[data_wd-2:0], sda_in};
      if (sample && sda_in && (state == S_AACK || (state == S_DACK && !rw_lat)))
        nack_flag <= 1'b1;
    end
  end

  // Response pulse on the cycle after the last STOP clock; data held until next completion
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_nack  <= 1'b0;
    end else begin
      rsp_valid <= (state == S_STOP) && bit_end;
      if ((state == S_STOP) && bit_end) begin
        rsp_nack  <= nack_flag;
        rsp_rdata <= (rw_lat && !nack_flag) ? data_sh : '0;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_i2c_master_ctrl.sv
//==============================================================================
// Module : tb_i2c_master_ctrl
// Brief  : Self-checking bench for i2c_master_ctrl with a bus-level slave
//          memory model and a command-level expectation model.
// Rev    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_i2c_master_ctrl;

  localparam int DW = 8;
  localparam int AW = 7;
  localparam int CD = 4;
  localparam int P  = 4 * CD;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_rw = 1'b0;
  logic [AW-1:0] cmd_addr = '0;
  logic [DW-1:0] cmd_wdata = '0;
  logic          cmd_ready, rsp_valid, rsp_nack, busy, scl, sda_oe, sda_in;
  logic [DW-1:0] rsp_rdata;

  logic slave_pull = 1'b0;
  logic slave_present = 1'b1;
  assign sda_in = ~(sda_oe | slave_pull);

  always #5 clk = ~clk;

  i2c_master_ctrl #(.data_wd(DW), .addr_wd(AW), .CLK_DIV(CD)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rw(cmd_rw),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_nack(rsp_nack),
    .busy(busy), .scl(scl), .sda_oe(sda_oe), .sda_in(sda_in)
  );

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [DW-1:0] model_mem [128];
  logic [DW-1:0] slave_mem [128];

  // Bus monitor / slave: frame bit k is sampled on each scl rise
  logic prev_scl = 1'b1, prev_sda = 1'b1;
  int   starts = 0, stops = 0, k = 0, rsp_cnt = 0;
  logic frame [0:31];
  int   base_s = 0, base_p = 0, base_r = 0;

  function automatic logic [AW-1:0] mon_addr();
    logic [AW-1:0] a;
    for (int i = 0; i < AW; i++) a[AW-1-i] = frame[i];
    return a;
  endfunction

  function automatic logic [DW-1:0] mon_data();
    logic [DW-1:0] d;
    for (int i = 0; i < DW; i++) d[DW-1-i] = frame[9+i];
    return d;
  endfunction

  function automatic logic slave_drive(input int n);
    logic [DW-1:0] b;
    if (!slave_present) return 1'b0;
    if (n == 8) return 1'b1;
    if (n == 17 && !frame[7]) return 1'b1;
    if (n >= 9 && n <= 16 && frame[7]) begin
      b = slave_mem[mon_addr()];
      return ~b[16-n];
    end
    return 1'b0;
  endfunction

  always @(negedge clk) begin
    if (rsp_valid) rsp_cnt++;
    if (!rst_n) begin
      slave_pull = 1'b0;
      k = 0;
    end else if (prev_scl && scl && prev_sda && !sda_in) begin
      starts++;
      k = 0;
    end else if (prev_scl && scl && !prev_sda && sda_in) begin
      stops++;
      if (slave_present && k == 19 && !frame[7]) slave_mem[mon_addr()] = mon_data();
    end else if (!prev_scl && scl) begin
      if (k < 32) frame[k] = sda_in;
      k++;
    end else if (prev_scl && !scl) begin
      slave_pull = slave_drive(k);
    end
    prev_scl = scl;
    prev_sda = sda_in;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic issue(input logic rw, input logic [AW-1:0] a, input logic [DW-1:0] d,
                       input bit pulses, output int t0);
    int guard = 0;
    @(negedge clk);
    while (!cmd_ready && guard < 1000) begin @(negedge clk); guard++; end
    chk("ready_before_issue", cmd_ready, 1);
    cmd_valid = 1'b1; cmd_rw = rw; cmd_addr = a; cmd_wdata = d;
    @(negedge clk);
    t0 = cyc;
    chk("busy_after_accept", busy, 1);
    chk("ready_low_when_busy", cmd_ready, 0);
    cmd_valid = 1'b0;
    if (pulses) begin
      for (int i = 0; i < 40; i++) begin
        cmd_valid = 1'($urandom_range(0, 1));
        cmd_rw    = 1'($urandom);
        cmd_addr  = AW'($urandom);
        cmd_wdata = DW'($urandom);
        @(negedge clk);
      end
      cmd_valid = 1'b0;
    end
  endtask

  task automatic finish_txn(input logic rw, input logic [AW-1:0] a, input logic [DW-1:0] d,
                            input logic present, input int t0, output int t_rsp);
    int guard = 0;
    logic [DW-1:0] exp_rd, held_rd;
    logic held_nack;
    while (!rsp_valid && guard < 2000) begin @(negedge clk); guard++; end
    chk("rsp_valid_seen", rsp_valid, 1);
    exp_rd = (present && rw) ? model_mem[a] : '0;
    chk("latency", cyc - t0, present ? 20 * P : 11 * P);
    chk("rsp_nack", rsp_nack, !present);
    chk("rsp_rdata", rsp_rdata, exp_rd);
    chk("busy_on_rsp", busy, 1);
    chk("ready_on_rsp", cmd_ready, 1);
    chk("bus_addr", mon_addr(), a);
    chk("bus_rw", frame[7], rw);
    chk("bus_aack", frame[8], !present);
    chk("bus_bits", k, present ? 19 : 10);
    chk("start_count", starts - base_s, 1);
    chk("stop_count", stops - base_p, 1);
    if (present) begin
      chk("bus_data", mon_data(), rw ? model_mem[a] : d);
      chk("bus_dack", frame[17], rw);
      if (!rw) model_mem[a] = d;
    end
    base_s = starts; base_p = stops;
    t_rsp = cyc;
    held_rd = rsp_rdata; held_nack = rsp_nack;
    @(negedge clk);
    chk("rsp_one_cycle", rsp_valid, 0);
    chk("rsp_pulses", rsp_cnt - base_r, 1);
    chk("rsp_rdata_held", rsp_rdata, held_rd);
    chk("rsp_nack_held", rsp_nack, held_nack);
    base_r = rsp_cnt;
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
    $fatal(1);
  end

  initial begin
    int t0, tr, guard;
    logic rw;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic pr;
    for (int i = 0; i < 128; i++) begin
      model_mem[i] = DW'($urandom);
      slave_mem[i] = model_mem[i];
    end
    for (int i = 0; i < 32; i++) frame[i] = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_scl", scl, 1);
    chk("rst_sda_oe", sda_oe, 0);
    chk("rst_ready", cmd_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rdata", rsp_rdata, 0);
    chk("rst_nack", rsp_nack, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_scl", scl, 1);
    chk("idle_sda_oe", sda_oe, 0);
    base_s = starts; base_p = stops; base_r = rsp_cnt;

    // Write 0x15 <- 0xA5, with stray cmd_valid pulses while busy
    issue(1'b0, 7'h15, 8'hA5, 1'b1, t0);
    finish_txn(1'b0, 7'h15, 8'hA5, 1'b1, t0, tr);

    // Read back the write
    issue(1'b1, 7'h15, 8'h00, 1'b0, t0);
    finish_txn(1'b1, 7'h15, 8'h00, 1'b1, t0, tr);

    // Read 0x7F holding 0x3C
    model_mem[7'h7F] = 8'h3C;
    slave_mem[7'h7F] = 8'h3C;
    issue(1'b1, 7'h7F, 8'hFF, 1'b1, t0);
    finish_txn(1'b1, 7'h7F, 8'hFF, 1'b1, t0, tr);
    chk("read_7f_value", rsp_rdata, 8'h3C);

    // No slave: address NACK, both directions
    slave_present = 1'b0;
    issue(1'b0, 7'h22, 8'h5A, 1'b0, t0);
    finish_txn(1'b0, 7'h22, 8'h5A, 1'b0, t0, tr);
    issue(1'b1, 7'h33, 8'h00, 1'b0, t0);
    finish_txn(1'b1, 7'h33, 8'h00, 1'b0, t0, tr);
    slave_present = 1'b1;

    // Back-to-back: cmd_valid held high, second command accepted on rsp cycle
    @(negedge clk);
    cmd_valid = 1'b1; cmd_rw = 1'b0; cmd_addr = 7'h41; cmd_wdata = 8'hC3;
    @(negedge clk);
    t0 = cyc;
    cmd_rw = 1'b1; cmd_addr = 7'h41; cmd_wdata = 8'h00;
    finish_txn(1'b0, 7'h41, 8'hC3, 1'b1, t0, tr);
    cmd_valid = 1'b0;
    chk("b2b_busy", busy, 1);
    finish_txn(1'b1, 7'h41, 8'h00, 1'b1, tr + 1, tr);

    // Reset in the middle of read data
    issue(1'b1, 7'h15, 8'h00, 1'b0, t0);
    guard = 0;
    while (k < 12 && guard < 1000) begin @(negedge clk); guard++; end
    chk("reached_rdata", (k >= 12), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_scl", scl, 1);
    chk("midrst_sda_oe", sda_oe, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_ready", cmd_ready, 1);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (400) @(negedge clk);
    chk("midrst_no_rsp", rsp_cnt - base_r, 0);
    base_s = starts; base_p = stops; base_r = rsp_cnt;
    issue(1'b1, 7'h15, 8'h00, 1'b0, t0);
    finish_txn(1'b1, 7'h15, 8'h00, 1'b1, t0, tr);

    // Randomized transactions over a small address window
    for (int n = 0; n < 8; n++) begin
      rw = 1'($urandom_range(0, 1));
      a  = AW'($urandom_range(0, 3));
      d  = DW'($urandom);
      pr = ($urandom_range(0, 5) != 0);
      slave_present = pr;
      issue(rw, a, d, 1'($urandom_range(0, 1)), t0);
      finish_txn(rw, a, d, pr, t0, tr);
    end
    slave_present = 1'b1;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
